// File: rtl/fact_ctrl.sv
// Control FSM for an iterative factorial datapath: sequences counter/product loads,
// reports busy/done/err, and forces an error if a run overstays TIMEOUT busy cycles.
module fact_ctrl #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic gt_in,
  input  logic gt_fact,
  output logic load_cnt,
  output logic en,
  output logic sel_1,
  output logic load_reg,
  output logic sel_2,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // Compare one below TIMEOUT so the ERR transition lands after exactly TIMEOUT busy cycles.
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCheck,
    StMul,
    StDone,
    StErr
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic            r_go_q;
  logic [TW-1:0]   r_tmo;
  logic            w_start;
  logic            w_busy;
  logic            w_tmo_hit;

  always_comb begin
    w_start   = go & ~r_go_q;
    w_busy    = (r_state == StInit) || (r_state == StCheck) || (r_state == StMul);
    w_tmo_hit = w_busy && (r_tmo == TmoLast);

    w_next = r_state;
    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (w_start) w_next = gt_in ? StErr : StInit;
      end
      StInit:  w_next = StCheck;
      StCheck: w_next = gt_fact ? StMul : StDone;
      StMul:   w_next = StCheck;
      default: w_next = StIdle;
    endcase

    if (w_tmo_hit) w_next = StErr;
  end

  // Outputs are registered from the next state, so each one is a pure decode of r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_go_q   <= 1'b0;
      r_tmo    <= '0;
      load_cnt <= 1'b0;
      en       <= 1'b0;
      sel_1    <= 1'b0;
      load_reg <= 1'b0;
      sel_2    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go_q  <= go;

      if (w_next == StInit) begin
        r_tmo <= '0;
      end else if (w_busy) begin
        r_tmo <= r_tmo + TW'(1);
      end

      load_cnt <= (w_next == StInit);
      load_reg <= (w_next == StInit) || (w_next == StMul);
      sel_1    <= (w_next == StMul);
      en       <= (w_next == StMul);
      sel_2    <= (w_next == StDone);
      done     <= (w_next == StDone);
      err      <= (w_next == StErr);
      busy     <= (w_next == StInit) || (w_next == StCheck) || (w_next == StMul);
    end
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: a small datapath plus a run-level reference model compared
// against the controller outputs every cycle, with directed scenario checks.
module tb_fact_ctrl;

  localparam int unsigned TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        gt_in;
  logic        gt_fact;
  logic        load_cnt, en, sel_1, load_reg, sel_2, busy, done, err;
  int unsigned n_in = 0;
  bit          force_gt = 1'b0;

  int checks = 0;
  int failures = 0;

  fact_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .gt_in   (gt_in),
    .gt_fact (gt_fact),
    .load_cnt(load_cnt),
    .en      (en),
    .sel_1   (sel_1),
    .load_reg(load_reg),
    .sel_2   (sel_2),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: down-counter, product register, result gate.
  logic [31:0] dp_cnt = '0;
  logic [31:0] dp_prod = '0;
  logic [31:0] nf;

  assign gt_in   = (n_in > 12);
  assign gt_fact = force_gt || (dp_cnt > 32'd1);
  assign nf      = sel_2 ? dp_prod : 32'd0;

  always @(posedge clk) begin
    if (load_cnt) dp_cnt <= n_in;
    else if (en)  dp_cnt <= dp_cnt - 32'd1;
    if (load_reg) dp_prod <= sel_1 ? dp_prod * dp_cnt : 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks a run as (mode, offset into busy window, window length).
  localparam int MIdle = 0, MBusy = 1, MDone = 2, MErr = 3;
  int          m_mode = MIdle;
  int          m_k = 0;
  int          m_len = 0;
  bit          m_end_err = 1'b0;
  bit          m_prev_go = 1'b0;
  logic [31:0] m_fact = '0;

  function automatic logic [31:0] fact(input int unsigned x);
    logic [31:0] r = 32'd1;
    for (int unsigned i = 2; i <= x; i++) r = r * i;
    return r;
  endfunction

  function automatic int run_len(input int unsigned n, input bit frc);
    if (frc) return TIMEOUT;
    return (n < 2) ? 2 : 2 * int'(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode    <= MIdle;
      m_k       <= 0;
      m_prev_go <= 1'b0;
    end else begin
      m_prev_go <= go;
      if (m_mode != MBusy) begin
        if (go && !m_prev_go) begin
          if (n_in > 12) begin
            m_mode <= MErr;
          end else begin
            m_mode    <= MBusy;
            m_k       <= 0;
            m_len     <= (run_len(n_in, force_gt) < TIMEOUT) ? run_len(n_in, force_gt) : TIMEOUT;
            m_end_err <= (run_len(n_in, force_gt) >= TIMEOUT);
            m_fact    <= fact(n_in);
          end
        end
      end else if (m_k + 1 >= m_len) begin
        m_mode <= m_end_err ? MErr : MDone;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Cycle compare: INIT at offset 0, CHECK on odd offsets, MUL on even offsets > 0.
  always @(negedge clk) begin
    logic       b, ini, mul, dn, er;
    logic [7:0] exp_v, got_v;
    b     = (m_mode == MBusy);
    ini   = b && (m_k == 0);
    mul   = b && (m_k > 0) && (m_k % 2 == 0);
    dn    = (m_mode == MDone);
    er    = (m_mode == MErr);
    exp_v = {ini, mul, mul, ini | mul, dn, b, dn, er};
    got_v = {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err};
    chk("outputs", {24'd0, got_v}, {24'd0, exp_v});
    chk("nf", nf, dn ? m_fact : 32'd0);
  end

  task automatic wait_end(output int nbusy, output int nen, output bit seen);
    nbusy = 0;
    nen   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (en) nen++;
      if (done || err) seen = 1'b1;
    end
  endtask

  task automatic check_end(input string name, input int nbusy, input int nen, input bit seen,
                           input logic [31:0] exp_nf, input int exp_busy, input int exp_en,
                           input bit exp_err);
    chk({name, " finished"}, {31'd0, seen}, 32'd1);
    chk({name, " busy_cycles"}, nbusy, exp_busy);
    chk({name, " en_cycles"}, nen, exp_en);
    chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, " nf"}, nf, exp_nf);
  endtask

  task automatic run(input string name, input int unsigned n, input logic [31:0] exp_nf,
                     input int exp_busy, input int exp_en, input bit exp_err);
    int nb, ne;
    bit sn;
    @(negedge clk);
    go   = 1'b0;
    n_in = n;
    @(negedge clk);
    go = 1'b1;
    wait_end(nb, ne, sn);
    check_end(name, nb, ne, sn, exp_nf, exp_busy, exp_en, exp_err);
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    int  nb, ne, cnt;
    bit  sn, found;

    // go high while in reset: must start on the first clock after release.
    go   = 1'b1;
    n_in = 3;
    #1;
    chk("reset outputs", {24'd0, load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}, 32'd0);
    #21 rst_n = 1'b1;
    wait_end(nb, ne, sn);
    check_end("go_at_release n=3", nb, ne, sn, 32'd6, 6, 2, 1'b0);
    @(negedge clk);
    go = 1'b0;

    run("n=5", 5, 32'd120, 10, 4, 1'b0);
    repeat (3) @(negedge clk);
    chk("n=5 nf held", nf, 32'd120);
    run("n=0", 0, 32'd1, 2, 0, 1'b0);
    run("n=1", 1, 32'd1, 2, 0, 1'b0);
    run("n=13", 13, 32'd0, 0, 0, 1'b1);
    run("n=12", 12, 32'd479001600, 24, 11, 1'b0);

    // go held high across what would be two runs: only one operation.
    @(negedge clk);
    go   = 1'b0;
    n_in = 4;
    @(negedge clk);
    go = 1'b1;
    wait_end(nb, ne, sn);
    check_end("held_go n=4", nb, ne, sn, 32'd24, 8, 3, 1'b0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (load_cnt) cnt++;
    end
    chk("held_go restarts", cnt, 0);

    // go toggled while busy: ignored.
    go   = 1'b0;
    n_in = 5;
    @(negedge clk);
    go = 1'b1;
    fork
      wait_end(nb, ne, sn);
      begin
        repeat (3) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
      end
    join
    check_end("toggle n=5", nb, ne, sn, 32'd120, 10, 4, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (load_cnt) cnt++;
    end
    chk("toggle restarts", cnt, 0);
    go = 1'b0;

    // Forced gt_fact: timeout after exactly TIMEOUT busy cycles.
    @(negedge clk);
    force_gt = 1'b1;
    run("timeout", 5, 32'd0, 32, 15, 1'b1);
    force_gt = 1'b0;

    // Asynchronous reset in MUL, then a clean run.
    @(negedge clk);
    n_in = 5;
    @(negedge clk);
    go    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (en) found = 1'b1;
    end
    chk("reached MUL", {31'd0, found}, 32'd1);
    go = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {24'd0, load_cnt, en, sel_1, load_reg, sel_2, busy, done, err},
        32'd0);
    chk("async reset nf", nf, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run("after_reset n=5", 5, 32'd120, 10, 4, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fact_ctrl.md
FACT_CTRL -- requirements
Module: fact_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32, meaning the maximum clock edges allowed in the busy states before a forced error.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port go, input, 1, level request; a start is its rising edge.
REQ-005 The block SHALL have port gt_in, input, 1, from the datapath: operand n > 12.
REQ-006 The block SHALL have port gt_fact, input, 1, from the datapath: down-counter value > 1.
REQ-007 The block SHALL have port load_cnt, output, 1, datapath counter load of n.
REQ-008 The block SHALL have port en, output, 1, datapath counter decrement enable.
REQ-009 The block SHALL have port sel_1, output, 1, product mux select (0 = constant 1, 1 = product times count).
REQ-010 The block SHALL have port load_reg, output, 1, datapath product register enable.
REQ-011 The block SHALL have port sel_2, output, 1, result output enable (nf = product when 1, else 0).
REQ-012 The block SHALL have ports busy, done and err, each output, 1, status.

Function
REQ-013 The FSM SHALL have states IDLE, INIT, CHECK, MUL, DONE, ERR, held in one state register; all outputs SHALL be Moore, decoded from state only.
REQ-014 Start edge SHALL be go & ~go_q, where go_q is go registered each cycle.
REQ-015 In IDLE, DONE or ERR, on a start edge: gt_in=1 -> ERR; gt_in=0 -> INIT; with no start edge, the state SHALL hold.
REQ-016 INIT SHALL assert load_cnt=1, load_reg=1, sel_1=0 and go to CHECK.
REQ-017 CHECK SHALL assert no datapath controls; gt_fact=1 -> MUL, gt_fact=0 -> DONE.
REQ-018 MUL SHALL assert load_reg=1, sel_1=1, en=1 (product *= count and count -= 1 on the same edge) and go to CHECK.
REQ-019 DONE SHALL assert sel_2=1 and done=1; ERR SHALL assert err=1 with sel_2=0.
REQ-020 busy SHALL be 1 exactly in INIT, CHECK and MUL; start edges while busy SHALL be ignored, not queued.
REQ-021 Latency from the start-edge sampling edge to entering DONE SHALL be 2 + 2*max(n-1,0) clock edges (n=0 and n=1 give 2 and result 1).
REQ-022 A timeout counter of width clog2(TIMEOUT+1) SHALL clear on entry to INIT and increment each busy cycle; reaching TIMEOUT while busy SHALL force ERR on the next edge.
REQ-023 The timeout SHALL have priority over the CHECK/MUL transitions on the same edge.
REQ-024 go held high SHALL produce exactly one start; a new start requires go to return low for at least one sampled cycle.
REQ-025 n is sampled by the datapath only in INIT; the block SHALL NOT depend on n after INIT.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, go_q=0 and timeout counter=0, and drive all outputs 0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done or err pulse; the datapath product register is not cleared by this block.
REQ-028 go already high at reset release SHALL count as a start edge on the first clock (go_q=0).

Verification
REQ-029 Bench: n=5, go pulse -> busy for 10 cycles, then done=1, sel_2=1 with nf=120 until the next start.
REQ-030 Bench: n=0 and n=1 -> done after 2 edges, nf=1; en never asserted.
REQ-031 Bench: n=13, go rise -> err=1 on the next edge, busy never 1, nf=0; n=12 -> done, nf=479001600 after 24 edges.
REQ-032 Bench: go held high through two complete runs -> exactly one operation; a go toggle during busy -> no effect.
REQ-033 Bench: gt_fact forced to 1 with TIMEOUT=32 -> err=1 exactly 32 busy cycles after INIT entry.
REQ-034 Bench: rst_n pulsed low during MUL (asynchronous, between edges) -> outputs 0 at once, state IDLE, and the next go runs correctly.
